word_serializer: RTL and testbench
==================================

Name: word_serializer

Overview:
- Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit at a time.
- Emits a per-bit shift strobe that drives the `en` of a ShiftRegisterSIPO receiver configured with `left=1`.
- Sits between a datapath/register source and a serial link, or a remote SIPO capture register.
- Supports gapless back-to-back words and a synchronous abort.

Parameters:
- WIDTH, 32, word width in bits (≥2).
- CLKS_PER_BIT, 1, clock cycles each bit is held on serial_out (≥1).
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first (matches SIPO left shift); 0 = bit 0 first.

Ports:
- clock, input, 1, single clock; all state on posedge.
- reset_L, input, 1, asynchronous active-low reset.
- data_in, input, WIDTH, word to transmit; sampled on accept.
- in_valid, input, 1, source has a word on data_in.
- in_ready, output, 1, serializer can accept; transfer occurs at the posedge where in_valid & in_ready.
- abort, input, 1, synchronous cancel of the word in flight.
- serial_out, output, 1, current bit.
- shift_en, output, 1, one-cycle strobe in the last cycle of each bit period; receiver samples serial_out when it is high.
- busy, output, 1, high while a word is being shifted.
- word_done, output, 1, one-cycle pulse coincident with the final bit's shift_en.

Behaviour:
- Reset (reset_L low, asynchronous): state IDLE; shift register, bit counter and clock-divider counter cleared.
  - Outputs during reset: serial_out=0, shift_en=0, busy=0, word_done=0, in_ready=0.
  - in_ready rises combinationally once reset_L deasserts, because state is IDLE.
- FSM states: IDLE, SHIFT.
- IDLE:
  - in_ready = ~abort; serial_out=0; busy=0.
  - On accept: load data_in into the shift register, bit_cnt=0, div_cnt=0, go to SHIFT.
- SHIFT:
  - busy=1.
  - serial_out = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - div_cnt counts 0..CLKS_PER_BIT-1; shift_en = (div_cnt==CLKS_PER_BIT-1).
  - On a shift_en cycle with bit_cnt<WIDTH-1: shift the register toward the output end (zero fill), bit_cnt++, div_cnt=0.
  - On a shift_en cycle with bit_cnt==WIDTH-1 (final bit): word_done=1 and in_ready=~abort.
    - If accepted this cycle: reload from data_in, bit_cnt=0, div_cnt=0, stay in SHIFT (no idle gap).
    - If not accepted: go to IDLE.
  - in_ready=0 in all other SHIFT cycles.
- Latency, accept at posedge T (cycle T = cycle before the edge):
  - First bit is on serial_out in cycle T+1.
  - With CLKS_PER_BIT=1: shift_en is high in cycles T+1..T+WIDTH, and word_done is high in cycle T+WIDTH.
  - General case: word_done is high in cycle T+WIDTH*CLKS_PER_BIT.
- Throughput: one word per WIDTH*CLKS_PER_BIT cycles with in_valid held high.
- abort:
  - In SHIFT: next state is IDLE, counters cleared, no word_done.
  - abort has priority over accept and over a coincident final-bit word_done; word_done is suppressed that cycle.
  - In IDLE: abort only blocks acceptance.
- data_in is don't-care except at an accept edge.
- in_valid deasserted at the final bit leaves the block in IDLE with serial_out=0.
- Reset asserted mid-word: immediate return to reset values; no partial word_done.
- shift_en and word_done are never high outside SHIFT.

Test Plan:
- Reset: hold reset_L=0 with in_valid=1 and clock running -> in_ready=0, busy=0, serial_out=0, no shift_en; release -> in_ready=1 while idle.
- Single word (WIDTH=8, CLKS_PER_BIT=1, MSB_FIRST=1), data_in=8'hA5 accepted at T -> serial_out 1,0,1,0,0,1,0,1 in cycles T+1..T+8; shift_en high in each of those cycles; word_done only at T+8; the SIPO receiver holds 8'hA5 afterward.
- Back-to-back: in_valid held high with 8'h3C then 8'hC3 -> in_ready high at T+8; second word's MSB on serial_out at T+9; 16 contiguous shift_en cycles; word_done at T+8 and T+16.
- Divider and LSB first (CLKS_PER_BIT=3, MSB_FIRST=0), 8'h01 -> serial_out=1 for cycles T+1..T+3, then 0; shift_en at T+3, T+6, …, T+24; word_done at T+24.
- Abort: accept 8'hFF, assert abort at T+4 -> busy=0 from T+5, no word_done, in_ready=0 during abort; next word 8'h81 is transmitted correctly.
- Async reset mid-word: drop reset_L at T+3 between edges -> outputs go to reset values immediately, before the next posedge; no word_done.

Source files
------------

// File: rtl/word_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready intake, per-bit shift strobe
// for a left-shifting SIPO receiver, gapless back-to-back words and synchronous abort.
module word_serializer #(
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             serial_out,
  output logic             shift_en,
  output logic             busy,
  output logic             word_done
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [DW-1:0]    div_cnt_q;

  logic in_shift;
  logic final_bit;
  logic accept;

  always_comb begin
    in_shift   = (state_q == SHIFT);
    shift_en   = in_shift && (div_cnt_q == DW'(CLKS_PER_BIT - 1));
    final_bit  = shift_en && (bit_cnt_q == BW'(WIDTH - 1));
    // reset_L gating holds in_ready low while reset is asserted.
    in_ready   = reset_L && !abort && (!in_shift || final_bit);
    accept     = in_valid && in_ready;
    word_done  = final_bit && !abort;
    busy       = in_shift;
    serial_out = in_shift && ((MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0]);
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else if (in_shift && abort) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else if (accept) begin
      state_q   <= SHIFT;
      shreg_q   <= data_in;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else if (in_shift) begin
      if (final_bit) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        div_cnt_q <= '0;
      end else if (shift_en) begin
        if (MSB_FIRST != 0) shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
        else                shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
        bit_cnt_q <= bit_cnt_q + BW'(1);
        div_cnt_q <= '0;
      end else begin
        div_cnt_q <= div_cnt_q + DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: an 8-bit MSB-first instance feeding a SIPO
// model, and an 8-bit LSB-first instance with a 3-clock bit period.
module tb_word_serializer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_L;
  logic [7:0] a_data, b_data;
  logic       a_valid, a_abort, a_ready, a_so, a_se, a_busy, a_done;
  logic       b_valid, b_abort, b_ready, b_so, b_se, b_busy, b_done;
  logic [7:0] rx;

  int checks = 0;
  int errors = 0;

  word_serializer #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1)) dut_a (
    .clock(clock), .reset_L(reset_L), .data_in(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .abort(a_abort), .serial_out(a_so), .shift_en(a_se),
    .busy(a_busy), .word_done(a_done)
  );

  word_serializer #(.WIDTH(8), .CLKS_PER_BIT(3), .MSB_FIRST(0)) dut_b (
    .clock(clock), .reset_L(reset_L), .data_in(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .abort(b_abort), .serial_out(b_so), .shift_en(b_se),
    .busy(b_busy), .word_done(b_done)
  );

  // SIPO receiver, left shift, capturing on each shift strobe.
  always @(posedge clock) if (a_se) rx <= {rx[6:0], a_so};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    a_valid = 1'b1; a_data = 8'hFF; a_abort = 1'b0;
    b_valid = 1'b1; b_data = 8'hFF; b_abort = 1'b0;
    rx = '0;
    repeat (3) @(posedge clock);
    #2;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset a_in_ready got %b exp 0", a_ready); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset a_busy got %b exp 0", a_busy); end
    checks++; if (a_so !== 1'b0) begin errors++; $display("FAIL reset a_serial_out got %b exp 0", a_so); end
    checks++; if (a_se !== 1'b0) begin errors++; $display("FAIL reset a_shift_en got %b exp 0", a_se); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset a_word_done got %b exp 0", a_done); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset b_in_ready got %b exp 0", b_ready); end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clock);
    reset_L = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_release a_in_ready got %b exp 1", a_ready); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_release b_in_ready got %b exp 1", b_ready); end
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'hA5;
    tick();
    a_valid = 1'b1; a_data = w;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single in_ready at T got %b exp 1", a_ready); end
    for (int i = 1; i <= 8; i++) begin
      tick();
      a_valid = 1'b0;
      #1;
      checks++; if (a_so !== w[8-i]) begin errors++; $display("FAIL single serial_out T+%0d got %b exp %b", i, a_so, w[8-i]); end
      checks++; if (a_se !== 1'b1) begin errors++; $display("FAIL single shift_en T+%0d got %b exp 1", i, a_se); end
      checks++; if (a_done !== (i == 8)) begin errors++; $display("FAIL single word_done T+%0d got %b exp %b", i, a_done, (i == 8)); end
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL single busy T+%0d got %b exp 1", i, a_busy); end
    end
    tick();
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL single busy after got %b exp 0", a_busy); end
    checks++; if (a_so !== 1'b0) begin errors++; $display("FAIL single idle serial_out got %b exp 0", a_so); end
    checks++; if (a_se !== 1'b0) begin errors++; $display("FAIL single idle shift_en got %b exp 0", a_se); end
    checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL single sipo got %h exp a5", rx); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w1, w2, w;
    int         b;
    w1 = 8'h3C; w2 = 8'hC3;
    tick();
    a_valid = 1'b1; a_data = w1;
    #1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1) a_data = w2;
      if (i == 9) a_valid = 1'b0;
      #1;
      w = (i <= 8) ? w1 : w2;
      b = (i <= 8) ? 8 - i : 16 - i;
      checks++; if (a_so !== w[b]) begin errors++; $display("FAIL b2b serial_out T+%0d got %b exp %b", i, a_so, w[b]); end
      checks++; if (a_se !== 1'b1) begin errors++; $display("FAIL b2b shift_en T+%0d got %b exp 1", i, a_se); end
      checks++; if (a_done !== (i == 8 || i == 16)) begin errors++; $display("FAIL b2b word_done T+%0d got %b exp %b", i, a_done, (i == 8 || i == 16)); end
      if (i <= 8) begin
        checks++; if (a_ready !== (i == 8)) begin errors++; $display("FAIL b2b in_ready T+%0d got %b exp %b", i, a_ready, (i == 8)); end
      end
    end
    tick();
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL b2b busy after got %b exp 0", a_busy); end
    checks++; if (rx !== 8'hC3) begin errors++; $display("FAIL b2b sipo got %h exp c3", rx); end
  endtask

  task automatic test_divider_lsb();
    tick();
    b_valid = 1'b1; b_data = 8'h01;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL div in_ready at T got %b exp 1", b_ready); end
    for (int i = 1; i <= 24; i++) begin
      tick();
      b_valid = 1'b0;
      #1;
      checks++; if (b_so !== (i <= 3)) begin errors++; $display("FAIL div serial_out T+%0d got %b exp %b", i, b_so, (i <= 3)); end
      checks++; if (b_se !== (i % 3 == 0)) begin errors++; $display("FAIL div shift_en T+%0d got %b exp %b", i, b_se, (i % 3 == 0)); end
      checks++; if (b_done !== (i == 24)) begin errors++; $display("FAIL div word_done T+%0d got %b exp %b", i, b_done, (i == 24)); end
    end
    tick();
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL div busy after got %b exp 0", b_busy); end
  endtask

  task automatic test_abort();
    logic [7:0] w;
    tick();
    a_valid = 1'b1; a_data = 8'hFF;
    #1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      a_valid = 1'b0;
      #1;
      checks++; if (a_so !== 1'b1) begin errors++; $display("FAIL abort serial_out T+%0d got %b exp 1", i, a_so); end
    end
    tick();
    a_abort = 1'b1; a_valid = 1'b1; a_data = 8'h81;
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL abort in_ready T+4 got %b exp 0", a_ready); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL abort word_done T+4 got %b exp 0", a_done); end
    tick();
    a_abort = 1'b0; a_valid = 1'b0;
    #1;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL abort busy T+5 got %b exp 0", a_busy); end
    checks++; if (a_so !== 1'b0) begin errors++; $display("FAIL abort serial_out T+5 got %b exp 0", a_so); end
    a_abort = 1'b1; a_valid = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL abort idle in_ready got %b exp 0", a_ready); end
    tick();
    a_abort = 1'b0; a_valid = 1'b0;
    #1;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL abort idle accepted busy got %b exp 0", a_busy); end
    w = 8'h81;
    a_valid = 1'b1; a_data = w;
    #1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      a_valid = 1'b0;
      #1;
      checks++; if (a_so !== w[8-i]) begin errors++; $display("FAIL abort next serial_out T+%0d got %b exp %b", i, a_so, w[8-i]); end
      checks++; if (a_done !== (i == 8)) begin errors++; $display("FAIL abort next word_done T+%0d got %b exp %b", i, a_done, (i == 8)); end
    end
    tick();
    checks++; if (rx !== 8'h81) begin errors++; $display("FAIL abort next sipo got %h exp 81", rx); end
    // Abort landing on the final bit must beat both word_done and a reload.
    a_valid = 1'b1; a_data = 8'h55;
    #1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      a_valid = (i == 8);
      a_abort = (i == 8);
      #1;
    end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL abort final word_done got %b exp 0", a_done); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL abort final in_ready got %b exp 0", a_ready); end
    tick();
    a_abort = 1'b0; a_valid = 1'b0;
    #1;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL abort final busy got %b exp 0", a_busy); end
  endtask

  task automatic test_async_reset();
    tick();
    a_valid = 1'b1; a_data = 8'hA5;
    #1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      a_valid = 1'b0;
      #1;
    end
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL areset busy before got %b exp 1", a_busy); end
    #1;
    reset_L = 1'b0;
    #1;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL areset busy got %b exp 0", a_busy); end
    checks++; if (a_so !== 1'b0) begin errors++; $display("FAIL areset serial_out got %b exp 0", a_so); end
    checks++; if (a_se !== 1'b0) begin errors++; $display("FAIL areset shift_en got %b exp 0", a_se); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL areset word_done got %b exp 0", a_done); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL areset in_ready got %b exp 0", a_ready); end
    @(negedge clock);
    reset_L = 1'b1;
    tick();
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL areset release busy got %b exp 0", a_busy); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL areset release in_ready got %b exp 1", a_ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_divider_lsb();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
